wb_arbiter: RTL and testbench

Writeback arbiter and destination scoreboard for the register file write port. Three result producers (0: ALU, 1: FPU, 2: load unit) compete for the single write port that feeds the register writer. The block grants one producer per cycle round-robin and registers the winning write. It also tracks a 64-bit pending-write (busy) map over general and float registers for the issue stage.

---
 rtl/wb_arbiter.sv | 123 ++++++++++++
 tb/tb_wb_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// ============================================================================
//  Module   : wb_arbiter
//  Purpose  : Round-robin writeback arbiter for three result producers with a
//             registered register-file write port and a 64-entry busy map.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         req_valid_i,
    input  logic [2:0]         req_gfflag_i,
    input  logic [14:0]        req_num_i,
    input  logic [3*WIDTH-1:0] req_data_i,
    output logic [2:0]         req_ready_o,
    input  logic               iss_valid_i,
    input  logic               iss_gfflag_i,
    input  logic [4:0]         iss_num_i,
    output logic               iss_ready_o,
    output logic [63:0]        busy_o,
    output logic               w_gfflag_o,
    output logic [4:0]         w_num_o,
    output logic [WIDTH-1:0]   w_data_o,
    output logic               w_enable_o
);

    logic [1:0]       ptr_q, ptr_d;
    logic [63:0]      busy_q, busy_d;
    logic             wr_en_q;
    logic             wr_gf_q;
    logic [4:0]       wr_num_q;
    logic [WIDTH-1:0] wr_data_q;

    logic [1:0]       ord0, ord1, ord2;
    logic             gnt_any;
    logic [1:0]       gnt_idx;
    logic [5:0]       gnt_reg;
    logic             gnt_zero;
    logic [WIDTH-1:0] gnt_data;
    logic [5:0]       iss_reg;

    function automatic logic [1:0] next_idx(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign ord0 = ptr_q;
    assign ord1 = next_idx(ord0);
    assign ord2 = next_idx(ord1);

    // Lowest search position wins, so it is evaluated last.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = 2'd0;
        if (req_valid_i[ord2]) begin
            gnt_any = 1'b1;
            gnt_idx = ord2;
        end
        if (req_valid_i[ord1]) begin
            gnt_any = 1'b1;
            gnt_idx = ord1;
        end
        if (req_valid_i[ord0]) begin
            gnt_any = 1'b1;
            gnt_idx = ord0;
        end
        if (rst) begin
            gnt_any = 1'b0;
        end
    end

    assign req_ready_o = gnt_any ? (3'b001 << gnt_idx) : 3'b000;
    assign gnt_reg     = {req_gfflag_i[gnt_idx], req_num_i[gnt_idx*5 +: 5]};
    assign gnt_data    = req_data_i[gnt_idx*WIDTH +: WIDTH];
    assign gnt_zero    = (gnt_reg == 6'd0);

    assign iss_reg     = {iss_gfflag_i, iss_num_i};
    assign iss_ready_o = !busy_q[iss_reg];

    assign ptr_d = gnt_any ? next_idx(gnt_idx) : ptr_q;

    // Set is applied after clear so a fresh issue keeps ownership of the register.
    always_comb begin
        busy_d = busy_q;
        if (gnt_any) begin
            busy_d[gnt_reg] = 1'b0;
        end
        if (iss_valid_i && iss_ready_o && (iss_reg != 6'd0)) begin
            busy_d[iss_reg] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= 2'd0;
            busy_q    <= 64'd0;
            wr_en_q   <= 1'b0;
            wr_gf_q   <= 1'b0;
            wr_num_q  <= 5'd0;
            wr_data_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            wr_en_q <= gnt_any && !gnt_zero;
            if (gnt_any) begin
                wr_gf_q   <= gnt_reg[5];
                wr_num_q  <= gnt_reg[4:0];
                wr_data_q <= gnt_data;
            end
        end
    end

    assign busy_o     = busy_q;
    assign w_gfflag_o = wr_gf_q;
    assign w_num_o    = wr_num_q;
    assign w_data_o   = wr_data_q;
    assign w_enable_o = wr_en_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
// ============================================================================
//  Module   : tb_wb_arbiter
//  Purpose  : Self-checking bench for wb_arbiter with a write scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_arbiter;

    localparam int WIDTH = 32;

    logic               clk;
    logic               rst;
    logic [2:0]         req_valid;
    logic [2:0]         req_gfflag;
    logic [14:0]        req_num;
    logic [3*WIDTH-1:0] req_data;
    logic [2:0]         req_ready;
    logic               iss_valid;
    logic               iss_gfflag;
    logic [4:0]         iss_num;
    logic               iss_ready;
    logic [63:0]        busy;
    logic               w_gfflag;
    logic [4:0]         w_num;
    logic [WIDTH-1:0]   w_data;
    logic               w_enable;

    wb_arbiter #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .req_gfflag_i (req_gfflag),
        .req_num_i    (req_num),
        .req_data_i   (req_data),
        .req_ready_o  (req_ready),
        .iss_valid_i  (iss_valid),
        .iss_gfflag_i (iss_gfflag),
        .iss_num_i    (iss_num),
        .iss_ready_o  (iss_ready),
        .busy_o       (busy),
        .w_gfflag_o   (w_gfflag),
        .w_num_o      (w_num),
        .w_data_o     (w_data),
        .w_enable_o   (w_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        gf;
        logic [4:0]  num;
        logic [31:0] data;
    } wr_t;

    wr_t         sb_q[$];
    wr_t         last_w;
    logic [63:0] exp_b;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic gf,
                           input logic [4:0] n, input logic [31:0] d);
        req_valid[i]            = v;
        req_gfflag[i]           = gf;
        req_num[i*5 +: 5]       = n;
        req_data[i*WIDTH +: 32] = d;
    endtask

    // One clock: check grant/iss_ready, push the expected write, then check outputs.
    task automatic cycle(input logic [2:0] exp_gnt, input logic exp_iss,
                         input logic [63:0] exp_busy, input string tag);
        wr_t  e;
        logic en;
        int   g;
        #1;
        check({tag, "_gnt"}, {61'd0, req_ready}, {61'd0, exp_gnt});
        check({tag, "_issrdy"}, {63'd0, iss_ready}, {63'd0, exp_iss});
        en = 1'b0;
        if (exp_gnt != 3'b000) begin
            g      = exp_gnt[1] ? 1 : (exp_gnt[2] ? 2 : 0);
            e.gf   = req_gfflag[g];
            e.num  = req_num[g*5 +: 5];
            e.data = req_data[g*WIDTH +: 32];
            last_w = e;
            if ({e.gf, e.num} != 6'd0) begin
                sb_q.push_back(e);
                en = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check({tag, "_wen"}, {63'd0, w_enable}, {63'd0, en});
        if (en) begin
            e = sb_q.pop_front();
            check({tag, "_wr"}, {26'd0, w_gfflag, w_num, w_data}, {26'd0, e});
        end else begin
            check({tag, "_whold"}, {26'd0, w_gfflag, w_num, w_data}, {26'd0, last_w});
        end
        check({tag, "_busy"}, busy, exp_busy);
    endtask

    task automatic reset_phase(input string tag);
        rst = 1'b1;
        #1;
        check({tag, "_rdy"}, {61'd0, req_ready}, 64'd0);
        @(posedge clk);
        #1;
        check({tag, "_wen"}, {63'd0, w_enable}, 64'd0);
        check({tag, "_busy"}, busy, 64'd0);
        check({tag, "_wout"}, {26'd0, w_gfflag, w_num, w_data}, 64'd0);
        rst = 1'b0;
        sb_q.delete();
        last_w = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        req_gfflag = '0;
        req_num    = '0;
        req_data   = '0;
        iss_valid  = 1'b0;
        iss_gfflag = 1'b0;
        iss_num    = '0;
        last_w     = '0;

        reset_phase("rst0");

        // Single float write from producer 1
        set_req(1, 1'b1, 1'b1, 5'd5, 32'h3F80_0000);
        cycle(3'b010, 1'b1, 64'd0, "t1");
        set_req(1, 1'b0, 1'b0, 5'd0, 32'd0);
        cycle(3'b000, 1'b1, 64'd0, "t1_idle");

        // Saturated round robin from reset
        reset_phase("rst1");
        for (int i = 0; i < 3; i++) set_req(i, 1'b1, i[0], 5'(i + 1), 32'hA000_0000 + i);
        for (int k = 0; k < 6; k++) cycle(3'b001 << (k % 3), 1'b1, 64'd0, "t2");
        for (int i = 0; i < 3; i++) set_req(i, 1'b0, 1'b0, 5'd0, 32'd0);

        // Pointer at 2 wraps to producer 0 before producer 1
        set_req(1, 1'b1, 1'b0, 5'd9, 32'h0000_1111);
        cycle(3'b010, 1'b1, 64'd0, "t3a");
        set_req(0, 1'b1, 1'b0, 5'd10, 32'h0000_2222);
        cycle(3'b001, 1'b1, 64'd0, "t3b");
        set_req(0, 1'b0, 1'b0, 5'd0, 32'd0);
        cycle(3'b010, 1'b1, 64'd0, "t3c");
        set_req(1, 1'b0, 1'b0, 5'd0, 32'd0);

        // Busy tracking on general r7
        iss_valid = 1'b1; iss_gfflag = 1'b0; iss_num = 5'd7;
        cycle(3'b000, 1'b1, 64'h80, "t4_iss");
        cycle(3'b000, 1'b0, 64'h80, "t4_stall");
        iss_valid = 1'b0;
        set_req(2, 1'b1, 1'b0, 5'd7, 32'h0000_7777);
        cycle(3'b100, 1'b0, 64'd0, "t4_clr");
        iss_valid = 1'b1;
        set_req(2, 1'b1, 1'b0, 5'd7, 32'h0000_7778);
        cycle(3'b100, 1'b1, 64'h80, "t4_setwins");
        iss_valid = 1'b0;
        set_req(2, 1'b0, 1'b0, 5'd0, 32'd0);
        set_req(0, 1'b1, 1'b0, 5'd7, 32'h0000_7779);
        cycle(3'b001, 1'b0, 64'd0, "t4_clr2");
        set_req(0, 1'b0, 1'b0, 5'd0, 32'd0);

        // Write to hardwired zero register
        set_req(1, 1'b1, 1'b0, 5'd0, 32'hDEAD_BEEF);
        iss_valid = 1'b1; iss_gfflag = 1'b0; iss_num = 5'd0;
        cycle(3'b010, 1'b1, 64'd0, "t5_r0");
        set_req(1, 1'b0, 1'b0, 5'd0, 32'd0);
        iss_valid = 1'b0;
        cycle(3'b000, 1'b1, 64'd0, "t5_idle");

        // Fill busy map, then reset with all producers requesting
        exp_b = 64'd0;
        iss_valid = 1'b1;
        for (int n = 1; n < 8; n++) begin
            iss_gfflag = 1'b0; iss_num = 5'(n);
            exp_b = exp_b | (64'd1 << n);
            cycle(3'b000, 1'b1, exp_b, "t6_g");
        end
        for (int n = 16; n < 32; n++) begin
            iss_gfflag = 1'b1; iss_num = 5'(n);
            exp_b = exp_b | (64'd1 << (32 + n));
            cycle(3'b000, 1'b1, exp_b, "t6_f");
        end
        check("t6_map", busy, 64'hFFFF_0000_0000_00FE);
        iss_valid = 1'b0;
        for (int i = 0; i < 3; i++) set_req(i, 1'b1, i[0], 5'(i + 1), 32'hB000_0000 + i);
        reset_phase("rst2");
        cycle(3'b001, 1'b1, 64'd0, "t6_first");
        for (int i = 0; i < 3; i++) set_req(i, 1'b0, 1'b0, 5'd0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
